// File: rtl/scope_pkg.sv
// Shared encodings and defaults for the scope front-panel controller.
package scope_pkg;

  typedef enum logic [1:0] {
    MODE_CURSOR = 2'b00,
    MODE_OFFSET = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_LOCK   = 2'b11
  } mode_e;

  // Bit 0 of the index is the "increment" direction for cursor/offset moves.
  typedef enum logic [1:0] {
    BTN_DN_B = 2'd0,
    BTN_UP_B = 2'd1,
    BTN_DN_A = 2'd2,
    BTN_UP_A = 2'd3
  } btn_e;

  localparam int NUM_BTN      = 4;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/btn_debounce_repeat.sv
// One push-button: 2-FF synchroniser, tick-based debounce and auto-repeat.
module btn_debounce_repeat
  import scope_pkg::*;
#(
  parameter int DEB_TICKS = 2,
  parameter int RPT_DELAY = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_n,
  input  logic tick,
  input  logic flush,
  output logic step,
  output logic first
);

  localparam int MAXC = (DEB_TICKS > RPT_DELAY) ? DEB_TICKS : RPT_DELAY;
  localparam int CW   = clog2_min1(MAXC + 2);

  typedef enum logic [2:0] {ST_IDLE, ST_COUNT, ST_HELD, ST_REPEAT, ST_WAIT} st_e;

  logic [1:0]    r_sync;
  st_e           r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic          w_low;

  assign w_low     = ~r_sync[1];
  assign w_cnt_inc = r_cnt + 1'b1;

  // step/first are decoded in the tick cycle itself so the owner can act on the same edge.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    step       = 1'b0;
    first      = 1'b0;
    if (tick) begin
      if (!w_low) begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end else if (flush && (r_state == ST_HELD || r_state == ST_REPEAT)) begin
        w_state_nx = ST_WAIT;
      end else begin
        case (r_state)
          ST_IDLE, ST_COUNT: begin
            if (r_state == ST_IDLE) w_cnt_nx = CW'(1);
            else                    w_cnt_nx = w_cnt_inc;
            if (w_cnt_nx >= CW'(DEB_TICKS)) begin
              step       = 1'b1;
              first      = 1'b1;
              w_state_nx = ST_HELD;
              w_cnt_nx   = '0;
            end else begin
              w_state_nx = ST_COUNT;
            end
          end
          ST_HELD: begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc >= CW'(RPT_DELAY)) begin
              step       = 1'b1;
              w_state_nx = ST_REPEAT;
            end
          end
          ST_REPEAT: step = 1'b1;
          default:   ;
        endcase
      end
    end
  end

  // Reset lands in WAIT so a button held through reset must be released first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_state <= ST_WAIT;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], btn_n};
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

endmodule

// File: rtl/scope_ui_ctrl.sv
// Front-panel controller: buttons and mode switches to cursor/channel state for the VGA renderer.
module scope_ui_ctrl
  import scope_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int COORD_W   = 11,
  parameter  int SHIFT_W   = 4,
  parameter  int SCREEN_W  = SCREEN_W_DEF,
  parameter  int SCREEN_H  = SCREEN_H_DEF,
  parameter  int SHIFT_MAX = 11,
  parameter  int TICK_DIV  = 524288,
  parameter  int DEB_TICKS = 2,
  parameter  int RPT_DELAY = 8,
  parameter  int DEF_X1    = 32,
  parameter  int DEF_X2    = 90,
  parameter  int DEF_Y1    = 25,
  parameter  int DEF_Y2    = 100,
  parameter  int OFS_BASE  = 30,
  parameter  int OFS_STEP  = 100,
  localparam int CH_W      = clog2_min1(NUM_CH)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  mode,
  input  logic                        sel_x,
  input  logic                        sel_y,
  input  logic [1:0]                  en_sw,
  input  logic [CH_W-1:0]             ch_sel,
  input  logic [NUM_BTN-1:0]          btn_n,
  output logic [COORD_W-1:0]          cursor_x1,
  output logic [COORD_W-1:0]          cursor_x2,
  output logic [COORD_W-1:0]          cursor_y1,
  output logic [COORD_W-1:0]          cursor_y2,
  output logic                        cursor_x_en,
  output logic                        cursor_y_en,
  output logic [NUM_CH-1:0]           ch_en,
  output logic [NUM_CH*COORD_W-1:0]   ch_offset,
  output logic [NUM_CH*SHIFT_W-1:0]   ch_shift,
  output logic                        tick
);

  localparam int CNT_W = clog2_min1(TICK_DIV);
  localparam logic [COORD_W:0] XLIM = (COORD_W+1)'(SCREEN_W - 1);
  localparam logic [COORD_W:0] YLIM = (COORD_W+1)'(SCREEN_H - 1);

  function automatic logic [COORD_W-1:0] f_sat(input logic [COORD_W-1:0] v, input logic up,
                                                input logic [COORD_W:0] lim);
    logic [COORD_W:0] e;
    e = {1'b0, v};
    if (up)            e = (e >= lim) ? lim : e + 1'b1;
    else if (e != '0)  e = e - 1'b1;
    return e[COORD_W-1:0];
  endfunction

  function automatic logic f_can(input logic [COORD_W-1:0] v, input logic up,
                                 input logic [COORD_W:0] lim);
    return up ? ({1'b0, v} < lim) : (v != '0);
  endfunction

  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  mode_e              w_mode, r_mode_t;
  logic [CH_W-1:0]    r_ch_t;
  logic               w_flush, w_any, w_up, w_hi, w_act_first;
  logic [NUM_BTN-1:0] w_step, w_first, w_onehot;
  btn_e               w_btn;
  logic [COORD_W-1:0] r_x1, r_x2, r_y1, r_y2;
  logic               r_x_en, r_y_en;

  assign w_mode  = mode_e'(mode);
  assign w_flush = (w_mode != r_mode_t) || (ch_sel != r_ch_t);
  assign tick    = r_tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_mode_t <= MODE_CURSOR;
      r_ch_t   <= '0;
    end else begin
      r_tick <= (r_cnt == CNT_W'(TICK_DIV - 1));
      r_cnt  <= (r_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : r_cnt + 1'b1;
      if (r_tick) begin
        r_mode_t <= w_mode;
        r_ch_t   <= ch_sel;
      end
    end
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce_repeat #(.DEB_TICKS(DEB_TICKS), .RPT_DELAY(RPT_DELAY)) u_btn (
      .clock  (clock),
      .reset_n(reset_n),
      .btn_n  (btn_n[b]),
      .tick   (r_tick),
      .flush  (w_flush),
      .step   (w_step[b]),
      .first  (w_first[b])
    );
  end

  always_comb begin
    w_btn    = BTN_DN_B;
    w_onehot = '0;
    if      (w_step[3]) begin w_btn = BTN_UP_A; w_onehot = 4'b1000; end
    else if (w_step[2]) begin w_btn = BTN_DN_A; w_onehot = 4'b0100; end
    else if (w_step[1]) begin w_btn = BTN_UP_B; w_onehot = 4'b0010; end
    else if (w_step[0]) begin w_btn = BTN_DN_B; w_onehot = 4'b0001; end
  end

  assign w_any       = |w_step;
  assign w_up        = w_btn[0];
  assign w_hi        = w_btn[1];
  assign w_act_first = |(w_first & w_onehot);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x1   <= COORD_W'(DEF_X1);
      r_x2   <= COORD_W'(DEF_X2);
      r_y1   <= COORD_W'(DEF_Y1);
      r_y2   <= COORD_W'(DEF_Y2);
      r_x_en <= 1'b0;
      r_y_en <= 1'b0;
    end else if (r_tick && w_mode == MODE_CURSOR) begin
      r_x_en <= en_sw[0];
      r_y_en <= en_sw[1];
      if (w_any) begin
        case ({sel_y, sel_x})
          2'b01: if (w_hi) r_x1 <= f_sat(r_x1, w_up, XLIM); else r_x2 <= f_sat(r_x2, w_up, XLIM);
          2'b10: if (w_hi) r_y1 <= f_sat(r_y1, w_up, YLIM); else r_y2 <= f_sat(r_y2, w_up, YLIM);
          2'b11: begin
            // Gang moves all-or-nothing so cursor spacing never collapses at an edge.
            if (w_hi) begin
              if (f_can(r_y1, w_up, YLIM) && f_can(r_y2, w_up, YLIM)) begin
                r_y1 <= f_sat(r_y1, w_up, YLIM);
                r_y2 <= f_sat(r_y2, w_up, YLIM);
              end
            end else if (f_can(r_x1, w_up, XLIM) && f_can(r_x2, w_up, XLIM)) begin
              r_x1 <= f_sat(r_x1, w_up, XLIM);
              r_x2 <= f_sat(r_x2, w_up, XLIM);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cursor_x1   = r_x1;
  assign cursor_x2   = r_x2;
  assign cursor_y1   = r_y1;
  assign cursor_y2   = r_y2;
  assign cursor_x_en = r_x_en;
  assign cursor_y_en = r_y_en;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int OFS_RAW = OFS_BASE + c * OFS_STEP;
    localparam logic [COORD_W-1:0] OFS_DEF =
      COORD_W'((OFS_RAW > SCREEN_H - 1) ? SCREEN_H - 1 : OFS_RAW);

    logic [COORD_W-1:0] r_ofs;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_en;
    logic               w_hit;

    assign w_hit = w_any && (ch_sel == CH_W'(c));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_ofs   <= OFS_DEF;
        r_shift <= '0;
        r_en    <= 1'b0;
      end else if (r_tick && w_hit) begin
        case (w_mode)
          MODE_OFFSET:
            case (w_btn)
              BTN_UP_A: r_ofs <= f_sat(r_ofs, 1'b1, YLIM);
              BTN_DN_A: r_ofs <= f_sat(r_ofs, 1'b0, YLIM);
              BTN_UP_B: if (w_act_first) r_en <= ~r_en;
              BTN_DN_B: r_ofs <= OFS_DEF;
            endcase
          MODE_SHIFT:
            case (w_btn)
              BTN_UP_A: if (r_shift != '0) r_shift <= r_shift - 1'b1;
              BTN_DN_A: if (r_shift < SHIFT_W'(SHIFT_MAX)) r_shift <= r_shift + 1'b1;
              default:  ;
            endcase
          default: ;
        endcase
      end
    end

    assign ch_en[c]                       = r_en;
    assign ch_offset[c*COORD_W +: COORD_W] = r_ofs;
    assign ch_shift[c*SHIFT_W +: SHIFT_W]  = r_shift;
  end

endmodule

// File: tb/tb_scope_ui_ctrl.sv
// Directed + random bench for scope_ui_ctrl against a tick-level behavioural model.
module tb_scope_ui_ctrl;

  localparam int NUM_CH = 4, COORD_W = 11, SHIFT_W = 4;
  localparam int TICK_DIV = 4, DEB = 2, RPT = 3;
  localparam int XMAX = 639, YMAX = 479, SMAX = 11;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic [1:0]                mode = 2'b00;
  logic                      sel_x = 1'b0, sel_y = 1'b0;
  logic [1:0]                en_sw = 2'b00;
  logic [1:0]                ch_sel = 2'b00;
  logic [3:0]                btn_n = 4'b1111;
  logic [COORD_W-1:0]        cursor_x1, cursor_x2, cursor_y1, cursor_y2;
  logic                      cursor_x_en, cursor_y_en;
  logic [NUM_CH-1:0]         ch_en;
  logic [NUM_CH*COORD_W-1:0] ch_offset;
  logic [NUM_CH*SHIFT_W-1:0] ch_shift;
  logic                      tick;

  scope_ui_ctrl #(.NUM_CH(NUM_CH), .COORD_W(COORD_W), .SHIFT_W(SHIFT_W), .TICK_DIV(TICK_DIV),
                  .DEB_TICKS(DEB), .RPT_DELAY(RPT)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .sel_x(sel_x), .sel_y(sel_y),
    .en_sw(en_sw), .ch_sel(ch_sel), .btn_n(btn_n),
    .cursor_x1(cursor_x1), .cursor_x2(cursor_x2), .cursor_y1(cursor_y1), .cursor_y2(cursor_y2),
    .cursor_x_en(cursor_x_en), .cursor_y_en(cursor_y_en), .ch_en(ch_en),
    .ch_offset(ch_offset), .ch_shift(ch_shift), .tick(tick)
  );

  always #5 clock = ~clock;

  int vectors = 0, errors = 0;

  // Reference model state, advanced once per UI tick
  int   mx1, mx2, my1, my2, mofs[4], msh[4], n_low[4];
  bit   waiting[4];
  logic xen, yen;
  logic [3:0] men;
  logic [1:0] m_mode, m_ch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx1 = 32; mx2 = 90; my1 = 25; my2 = 100;
    xen = 1'b0; yen = 1'b0; men = '0;
    m_mode = 2'b00; m_ch = 2'b00;
    for (int c = 0; c < 4; c++) begin
      mofs[c] = 30 + 100 * c; msh[c] = 0; n_low[c] = 0; waiting[c] = 1'b1;
    end
  endtask

  function automatic int up(input int v, input int lim); return (v >= lim) ? lim : v + 1; endfunction
  function automatic int dn(input int v); return (v <= 0) ? 0 : v - 1; endfunction

  task automatic model_tick();
    bit flush;
    int act;
    bit fs[4];
    flush = (mode != m_mode) || (ch_sel != m_ch);
    m_mode = mode; m_ch = ch_sel;
    act = -1;
    for (int b = 0; b < 4; b++) begin
      fs[b] = 1'b0;
      if (btn_n[b]) begin
        n_low[b] = 0; waiting[b] = 1'b0;
      end else if (!waiting[b]) begin
        if (flush && n_low[b] >= DEB) waiting[b] = 1'b1;
        else begin
          n_low[b]++;
          if (n_low[b] == DEB) begin act = b; fs[b] = 1'b1; end
          else if (n_low[b] >= DEB + RPT) act = b;
        end
      end
    end
    case (mode)
      2'b00: begin
        xen = en_sw[0]; yen = en_sw[1];
        if (sel_x && !sel_y) begin
          if (act == 3) mx1 = up(mx1, XMAX); if (act == 2) mx1 = dn(mx1);
          if (act == 1) mx2 = up(mx2, XMAX); if (act == 0) mx2 = dn(mx2);
        end else if (sel_y && !sel_x) begin
          if (act == 3) my1 = up(my1, YMAX); if (act == 2) my1 = dn(my1);
          if (act == 1) my2 = up(my2, YMAX); if (act == 0) my2 = dn(my2);
        end else if (sel_x && sel_y) begin
          if (act == 3 && my1 < YMAX && my2 < YMAX) begin my1++; my2++; end
          if (act == 2 && my1 > 0 && my2 > 0) begin my1--; my2--; end
          if (act == 1 && mx1 < XMAX && mx2 < XMAX) begin mx1++; mx2++; end
          if (act == 0 && mx1 > 0 && mx2 > 0) begin mx1--; mx2--; end
        end
      end
      2'b01: begin
        if (act == 3) mofs[ch_sel] = up(mofs[ch_sel], YMAX);
        if (act == 2) mofs[ch_sel] = dn(mofs[ch_sel]);
        if (act == 1 && fs[1]) men[ch_sel] = ~men[ch_sel];
        if (act == 0) mofs[ch_sel] = 30 + 100 * int'(ch_sel);
      end
      2'b10: begin
        if (act == 3) msh[ch_sel] = dn(msh[ch_sel]);
        if (act == 2) msh[ch_sel] = up(msh[ch_sel], SMAX);
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("x1", 32'(cursor_x1), mx1);
    chk("x2", 32'(cursor_x2), mx2);
    chk("y1", 32'(cursor_y1), my1);
    chk("y2", 32'(cursor_y2), my2);
    chk("x_en", 32'(cursor_x_en), 32'(xen));
    chk("y_en", 32'(cursor_y_en), 32'(yen));
    chk("ch_en", 32'(ch_en), 32'(men));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ofs%0d", c), 32'(ch_offset[c*COORD_W +: COORD_W]), mofs[c]);
      chk($sformatf("shift%0d", c), 32'(ch_shift[c*SHIFT_W +: SHIFT_W]), msh[c]);
    end
  endtask

  // Wait (bounded) for the tick cycle, let its edge update the DUT, then advance and compare.
  task automatic step_tick();
    int g = 0;
    while (tick !== 1'b1 && g < 4 * TICK_DIV) begin
      @(negedge clock);
      g++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
    @(posedge clock);
    #1;
    chk("tick_pulse", 32'(tick), 32'd0);
    model_tick();
    check_all();
  endtask

  task automatic hold(input logic [3:0] low, input int t);
    btn_n = ~low;
    repeat (t) step_tick();
    btn_n = 4'b1111;
    step_tick();
  endtask

  initial begin
    int exp_ofs[4] = '{30, 130, 230, 330};
    model_reset();
    #12;
    check_all();
    for (int c = 0; c < 4; c++) chk("reset_ofs", 32'(ch_offset[c*COORD_W +: COORD_W]), exp_ofs[c]);
    @(negedge clock) reset_n = 1'b1;

    sel_x = 1'b1; en_sw = 2'b01;
    repeat (3) step_tick();
    btn_n[3] = 1'b0;
    repeat (2) step_tick();
    #13;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_x1", 32'(cursor_x1), 32);
    for (int c = 0; c < 4; c++) chk("reset_ofs2", 32'(ch_offset[c*COORD_W +: COORD_W]), exp_ofs[c]);
    @(negedge clock) reset_n = 1'b1;
    repeat (4) step_tick();
    chk("held_thru_reset", 32'(cursor_x1), 32);
    btn_n = 4'b1111;
    step_tick();

    hold(4'b1000, 1);  chk("glitch_x1", 32'(cursor_x1), 32);
    hold(4'b1000, 10); chk("repeat_x1", 32'(cursor_x1), 39);
    hold(4'b1000, 2);  chk("press_x1", 32'(cursor_x1), 40);

    hold(4'b0010, 600); chk("clamp_x2", 32'(cursor_x2), 639);
    sel_x = 1'b0; sel_y = 1'b1; en_sw = 2'b10;
    hold(4'b0010, 420); chk("clamp_y2", 32'(cursor_y2), 479);
    hold(4'b1000, 500); chk("clamp_y1", 32'(cursor_y1), 479);
    hold(4'b0100, 2);   chk("y1_dec", 32'(cursor_y1), 478);
    sel_x = 1'b1;
    hold(4'b1000, 10);
    chk("gang_y1", 32'(cursor_y1), 478);
    chk("gang_y2", 32'(cursor_y2), 479);

    mode = 2'b01; ch_sel = 2'd2;
    hold(4'b0010, 10);  chk("toggle_en2", 32'(ch_en[2]), 1);
    hold(4'b0100, 300); chk("ofs2_floor", 32'(ch_offset[2*COORD_W +: COORD_W]), 0);
    hold(4'b0001, 2);   chk("ofs2_restore", 32'(ch_offset[2*COORD_W +: COORD_W]), 230);

    mode = 2'b10; ch_sel = 2'd1;
    hold(4'b0100, 30); chk("shift1_sat", 32'(ch_shift[1*SHIFT_W +: SHIFT_W]), 11);
    hold(4'b1100, 5);  chk("shift1_prio", 32'(ch_shift[1*SHIFT_W +: SHIFT_W]), 9);

    mode = 2'b00; sel_x = 1'b1; sel_y = 1'b0;
    btn_n = 4'b0111;
    repeat (7) step_tick(); chk("rpt_x1", 32'(cursor_x1), 44);
    mode = 2'b11;
    repeat (3) step_tick(); chk("lock_x1", 32'(cursor_x1), 44);
    mode = 2'b00;
    repeat (3) step_tick(); chk("no_carry_x1", 32'(cursor_x1), 44);
    btn_n = 4'b1111;
    step_tick();
    hold(4'b1000, 2); chk("repress_x1", 32'(cursor_x1), 45);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) ch_sel = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) begin
        sel_x = 1'($urandom_range(1));
        sel_y = 1'($urandom_range(1));
      end
      if ($urandom_range(9) == 0) en_sw = 2'($urandom_range(3));
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) btn_n[b] = ~btn_n[b];
      step_tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
